// File: rtl/la_cellbist5.sv
// Exhaustive BIST for one 5-input cell: drives a registered 0..31 sweep,
// compares the (optionally pipelined) cell response against TRUTH and logs results.
module la_cellbist5 #(
    parameter string       PROP  = "DEFAULT",
    parameter logic [31:0] TRUTH = 32'h01FF_FFFF,
    parameter int unsigned LAT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [4:0] stim,
    input  logic       resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] errcnt,
    output logic [4:0] firstfail,
    output logic       failvalid
);

    localparam int unsigned PD   = (LAT == 0) ? 1 : LAT;
    localparam int unsigned LAST = PD - 1;
    localparam logic [4:0]  IDX_MAX = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // PROP only carries implementation hints through the hierarchy
    if (PROP == "") begin : g_prop_empty
    end

    state_e      state_q, state_d;
    logic [4:0]  stim_q, stim_d;
    logic [5:0]  errcnt_q, errcnt_d;
    logic [4:0]  firstfail_q, firstfail_d;
    logic        failvalid_q, failvalid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [PD-1:0] pv_q, pv_d;
    logic [4:0]  pidx_q [PD];
    logic [4:0]  pidx_d [PD];

    logic        sweep_start;
    logic        pipe_busy;
    logic        cmp_v;
    logic [4:0]  cmp_idx;
    logic        mismatch;

    assign sweep_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Valid entries still behind the final compare stage
    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i < LAST; i++) begin
            pipe_busy = pipe_busy | pv_q[i];
        end
    end

    // State register plus all datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stim_q      <= '0;
            errcnt_q    <= '0;
            firstfail_q <= '0;
            failvalid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            pv_q        <= '0;
            for (int unsigned i = 0; i < PD; i++) begin
                pidx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            errcnt_q    <= errcnt_d;
            firstfail_q <= firstfail_d;
            failvalid_q <= failvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            pv_q        <= pv_d;
            for (int unsigned i = 0; i < PD; i++) begin
                pidx_q[i] <= pidx_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (stim_q == IDX_MAX) state_d = (LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: if (!pipe_busy) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep counter, compare pipeline and result accumulation
    always_comb begin
        stim_d      = stim_q;
        errcnt_d    = errcnt_q;
        firstfail_d = firstfail_q;
        failvalid_d = failvalid_q;
        pv_d        = '0;
        pv_d[0]     = (state_q == S_RUN);
        pidx_d[0]   = stim_q;
        for (int unsigned i = 1; i < PD; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end

        // Zero latency compares the live stimulus against the same-cycle response
        cmp_v    = (LAT == 0) ? (state_q == S_RUN) : pv_q[LAST];
        cmp_idx  = (LAT == 0) ? stim_q : pidx_q[LAST];
        mismatch = cmp_v && (resp != TRUTH[cmp_idx]);

        if (sweep_start) begin
            stim_d      = '0;
            errcnt_d    = '0;
            firstfail_d = '0;
            failvalid_d = 1'b0;
        end else begin
            if ((state_q == S_RUN) && (stim_q != IDX_MAX)) begin
                stim_d = stim_q + 5'd1;
            end
            if (mismatch) begin
                errcnt_d = errcnt_q + 6'd1;
                if (!failvalid_q) begin
                    firstfail_d = cmp_idx;
                    failvalid_d = 1'b1;
                end
            end
        end
    end

    // Registered status outputs derived from the next state
    always_comb begin
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (errcnt_d == 6'd0);
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign errcnt    = errcnt_q;
    assign firstfail = firstfail_q;
    assign failvalid = failvalid_q;

endmodule

// File: tb/tb_la_cellbist5.sv
// Bench for la_cellbist5: three instances (LAT 0/1/2) each driven by a table-based
// cell with a configurable flop delay, checked against a sweep-level reference model.
module tb_la_cellbist5;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  stim [3];
    logic [2:0]  resp;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  pass;
    logic [5:0]  errcnt [3];
    logic [4:0]  firstfail [3];
    logic [2:0]  failvalid;

    logic [31:0] cell_tbl [3];
    int          dly [3];
    logic [31:0] exp_tbl;
    int          prev_stim;
    int          ncmp;
    int          nfail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] dq;
        always @(posedge clk) dq <= {dq[1:0], cell_tbl[g][stim[g]]};
        assign resp[g] = (dly[g] == 0) ? cell_tbl[g][stim[g]] : dq[2'(dly[g] - 1)];

        la_cellbist5 #(.LAT(g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .stim      (stim[g]),
            .resp      (resp[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .errcnt    (errcnt[g]),
            .firstfail (firstfail[g]),
            .failvalid (failvalid[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected sweep outcome: compare of index k sees the cell evaluated on the
    // stimulus present (LAT - delay) cycles later, clamped to the sweep range.
    function automatic void model(input logic [31:0] tbl, input int lat, input int d,
                                  input int prev, output int ec, output int ff, output bit fv);
        ec = 0;
        ff = 0;
        fv = 1'b0;
        for (int k = 0; k < 32; k++) begin
            int  j;
            int  s;
            j = k + lat - d;
            s = (j < 0) ? prev : ((j > 31) ? 31 : j);
            if (tbl[s] !== exp_tbl[k]) begin
                ec++;
                if (!fv) begin
                    ff = k;
                    fv = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk_reset();
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("rst_stim[%0d]", n), stim[n], 0);
            chk($sformatf("rst_busy_done[%0d]", n), {busy[n], done[n]}, 0);
            chk($sformatf("rst_pass[%0d]", n), pass[n], 0);
            chk($sformatf("rst_errcnt[%0d]", n), errcnt[n], 0);
            chk($sformatf("rst_firstfail[%0d]", n), firstfail[n], 0);
            chk($sformatf("rst_failvalid[%0d]", n), failvalid[n], 0);
        end
    endtask

    // One sweep on all instances; start held through edge E(hold), optional reset at stim==abort_at
    task automatic run_sweep(input int hold, input int abort_at);
        int ec;
        int ff;
        bit fv;
        repeat (4) @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 37; cyc++) begin
            @(negedge clk);
            if (cyc >= hold) start = 1'b0;
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("stim[%0d]@%0d", n, cyc), stim[n], (cyc > 31) ? 31 : cyc);
                chk($sformatf("busy_done[%0d]@%0d", n, cyc), {busy[n], done[n]},
                    (cyc < 32 + n) ? 2'b10 : 2'b01);
                if (cyc == 0) begin
                    chk($sformatf("clr_errcnt[%0d]", n), errcnt[n], 0);
                    chk($sformatf("clr_failvalid[%0d]", n), failvalid[n], 0);
                    chk($sformatf("clr_pass[%0d]", n), pass[n], 0);
                end
            end
            if (cyc == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                chk_reset();
                reset = 1'b0;
                prev_stim = 0;
                return;
            end
        end
        for (int n = 0; n < 3; n++) begin
            model(cell_tbl[n], n, dly[n], prev_stim, ec, ff, fv);
            chk($sformatf("errcnt[%0d]", n), errcnt[n], ec);
            chk($sformatf("firstfail[%0d]", n), firstfail[n], ff);
            chk($sformatf("failvalid[%0d]", n), failvalid[n], fv);
            chk($sformatf("pass[%0d]", n), pass[n], (ec == 0));
        end
        prev_stim = 31;
    endtask

    task automatic set_correct();
        for (int n = 0; n < 3; n++) begin
            cell_tbl[n] = exp_tbl;
            dly[n] = n;
        end
    endtask

    initial begin
        ncmp = 0;
        nfail = 0;
        // oai311: z = !((a0|a1|a2) & b0 & c0), stim = {c0,b0,a2,a1,a0}
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            exp_tbl[i] = !((v[0] | v[1] | v[2]) & v[3] & v[4]);
        end
        reset = 1'b1;
        start = 1'b0;
        set_correct();
        repeat (5) @(negedge clk);
        chk_reset();
        reset = 1'b0;
        prev_stim = 0;

        // Matched latencies, correct cells
        run_sweep(0, -1);
        for (int n = 0; n < 3; n++) chk($sformatf("s1_pass[%0d]", n), pass[n], 1);

        // Stuck-at cells
        cell_tbl[0] = 32'hFFFF_FFFF; dly[0] = 0;
        cell_tbl[1] = 32'h0000_0000; dly[1] = 1;
        run_sweep(0, -1);
        chk("s2_errcnt0", errcnt[0], 7);
        chk("s2_firstfail0", firstfail[0], 25);
        chk("s2_pass0", pass[0], 0);
        chk("s2_errcnt1", errcnt[1], 25);
        chk("s2_firstfail1", firstfail[1], 0);

        // Latency mismatch on LAT=1 plus random faulty cells elsewhere
        cell_tbl[0] = exp_tbl ^ ($urandom() & $urandom());
        cell_tbl[1] = exp_tbl; dly[1] = 2;
        cell_tbl[2] = $urandom();
        run_sweep(0, -1);
        chk("s3_lat_mismatch", (errcnt[1] != 0), 1);

        // Start held high through RUN, restarted from DONE after failures
        set_correct();
        run_sweep(20, -1);

        // Reset mid-sweep, then a fresh clean sweep
        run_sweep(0, 10);
        run_sweep(0, -1);
        for (int n = 0; n < 3; n++) chk($sformatf("s6_pass[%0d]", n), pass[n], 1);

        // Randomized sparse faults
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 3; n++) begin
                cell_tbl[n] = exp_tbl ^ ($urandom() & $urandom() & $urandom());
                dly[n] = n;
            end
            run_sweep(0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
